// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder slice.
//
// Contents:
//   WORD_W   - data word width (32).
//   MAX_WAIT - largest supported WAIT_STATES value (15).
//   CNT_W    - width of the wait-state counter, sized to hold MAX_WAIT.
//   state_e  - responder FSM state encoding (StIdle, StWait, StResp).
package mem_resp_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word RAM with synchronous write and registered read. There is no reset:
// the storage and the read register power up undefined, so the owner masks
// rdata until a read has actually completed.
//
// Ports:
//   Clk   - clock, rising edge.
//   we    - write enable; mem[idx] <= wdata on the edge.
//   re    - read enable; rdata <= mem[idx] on the edge, otherwise held.
//   idx   - word index.
//   wdata - write data.
//   rdata - registered read data, held between reads.
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned ABITS = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              we,
    input  logic              re,
    input  logic [ABITS-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder for the CPU memory port. A request is
// accepted in IDLE, waits WAIT_STATES cycles, performs the access and then
// pulses Ready (with Err) for one cycle in RESP.
//
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to flag Address[1:0] != 0
// as an error (handled like out of range). Undefined: low bits ignored.
//
// Ports:
//   Clk     - clock, rising edge.
//   Reset   - asynchronous active-low reset.
//   Req     - request strobe, sampled only in IDLE.
//   Wr      - 1 = write, 0 = read; sampled with Req.
//   Address - byte address; word index = Address[ABITS+1:2].
//   Datain  - write data; sampled with Req.
//   Dataout - last successful read data (0 after reset).
//   Ready   - one-cycle completion pulse.
//   Err     - error flag, meaningful while Ready = 1.
//   Busy    - high in WAIT and RESP.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ABITS       = $clog2(DEPTH_WORDS)
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Ready,
    output logic        Err,
    output logic        Busy
);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit AlignCheck = 1'b1;
`else
    localparam bit AlignCheck = 1'b0;
`endif

    localparam logic [CNT_W-1:0] WaitLoad =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;

    logic              access;
    logic              acc_wr;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic              mem_we;
    logic              mem_re;
    logic [ABITS-1:0]  mem_idx;
    logic [WORD_W-1:0] mem_rdata;

    // With zero wait states the access happens on the sampling edge, so it
    // must use the live inputs; otherwise it uses the latched request.
    always_comb begin
        if (state_q == StIdle) begin
            acc_wr    = Wr;
            acc_addr  = Address;
            acc_wdata = Datain;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_err = ((acc_addr >> (ABITS + 2)) != 32'd0) ||
                  (AlignCheck && (acc_addr[1:0] != 2'b00));
    end

    always_comb begin
        access = 1'b0;
        unique case (state_q)
            StIdle:  access = Req && (WAIT_STATES == 0);
            StWait:  access = (cnt_q == '0);
            default: access = 1'b0;
        endcase
    end

    // Errored accesses neither write nor disturb the read register.
    assign mem_we  = access && acc_wr && !acc_err;
    assign mem_re  = access && !acc_wr && !acc_err;
    assign mem_idx = acc_addr[ABITS+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        err_d      = err_q;
        rd_valid_d = rd_valid_q || mem_re;

        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    wr_d    = Wr;
                    addr_d  = Address;
                    wdata_d = Datain;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (access) begin
            ready_d = 1'b1;
            err_d   = acc_err;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    mem_word_array #(
        .DEPTH (DEPTH_WORDS),
        .ABITS (ABITS)
    ) u_array (
        .Clk   (Clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (mem_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // The RAM read register has no reset; show 0 until the first real read.
    assign Dataout = rd_valid_q ? mem_rdata : '0;
    assign Ready   = ready_q;
    assign Err     = err_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with WAIT_STATES = 1, 0 and 3.
// Expected completions go into a scoreboard queue when a request is driven
// and are popped and compared whenever the DUT pulses Ready.
module tb_mem_responder;

    localparam int N = 3;

    typedef struct {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req  [N];
    logic        wr   [N];
    logic [31:0] addr [N];
    logic [31:0] din  [N];
    logic [31:0] dout [N];
    logic        rdy  [N];
    logic        err  [N];
    logic        busy [N];

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .Clk(clk), .Reset(rst_n), .Req(req[0]), .Wr(wr[0]), .Address(addr[0]),
        .Datain(din[0]), .Dataout(dout[0]), .Ready(rdy[0]), .Err(err[0]), .Busy(busy[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .Clk(clk), .Reset(rst_n), .Req(req[1]), .Wr(wr[1]), .Address(addr[1]),
        .Datain(din[1]), .Dataout(dout[1]), .Ready(rdy[1]), .Err(err[1]), .Busy(busy[1])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .Clk(clk), .Reset(rst_n), .Req(req[2]), .Wr(wr[2]), .Address(addr[2]),
        .Datain(din[2]), .Dataout(dout[2]), .Ready(rdy[2]), .Err(err[2]), .Busy(busy[2])
    );

    function automatic int ws_of(int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(logic [31:0] d, logic e);
        exp_t x;
        x.dout = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Watch n cycles, recording Ready per cycle in vec and scoring each pulse.
    task automatic observe(int i, int n, bit drop, bit glitch, string tag,
                           output logic [31:0] vec);
        exp_t e;
        vec = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (drop && k == 0) req[i] = 1'b0;
            if (glitch && k == 1) begin
                req[i]  = 1'b1;
                wr[i]   = 1'b1;
                addr[i] = 32'h0000_0024;
                din[i]  = 32'h1111_1111;
            end
            if (glitch && k == 2) req[i] = 1'b0;
            vec[k] = rdy[i];
            if (rdy[i]) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_sb_underflow"}, {31'd0, rdy[i]}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_dataout"}, dout[i], e.dout);
                    check({tag, "_err"}, {31'd0, err[i]}, {31'd0, e.err});
                end
            end
        end
    endtask

    // One request pulse; Ready must appear exactly once, WAIT_STATES+1 cycles on.
    task automatic txn(int i, bit w, logic [31:0] a, logic [31:0] d,
                       logic [31:0] exp_dout, bit exp_err, bit glitch, string tag);
        logic [31:0] vec;
        push_exp(exp_dout, exp_err);
        @(negedge clk);
        req[i]  = 1'b1;
        wr[i]   = w;
        addr[i] = a;
        din[i]  = d;
        observe(i, ws_of(i) + 4, 1'b1, glitch, tag, vec);
        check({tag, "_ready"}, vec, 32'd1 << ws_of(i));
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] vec;
        int          rcnt;

        for (int i = 0; i < N; i++) begin
            req[i]  = 1'b0;
            wr[i]   = 1'b0;
            addr[i] = '0;
            din[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_dataout", dout[i], 32'd0);
            check("rst_ready", {31'd0, rdy[i]}, 32'd0);
            check("rst_err", {31'd0, err[i]}, 32'd0);
            check("rst_busy", {31'd0, busy[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // WAIT_STATES = 1: write leaves Dataout alone, read returns new data.
        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, "ws1_wr10");
        txn(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, "ws1_rd10");
        txn(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0, 1'b0, "ws1_wr0");
        // Out of range: write suppressed (0x400 would alias word 0), read holds Dataout.
        txn(0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0, "ws1_wr400");
        txn(0, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b0, "ws1_rd0");
        txn(0, 1'b0, 32'h0000_0400, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b0, "ws1_rd400");
        txn(0, 1'b0, 32'h8000_0010, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b0, "ws1_rdhigh");

        // WAIT_STATES = 0
        txn(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, "ws0_wr4");
        txn(1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0, 1'b0, "ws0_rd4");

        // Req held high: one completion every 2 cycles.
        for (int k = 0; k < 4; k++) push_exp(32'h1234_5678, 1'b0);
        @(negedge clk);
        req[1]  = 1'b1;
        wr[1]   = 1'b0;
        addr[1] = 32'h0000_0004;
        observe(1, 8, 1'b0, 1'b0, "ws0_b2b", vec);
        req[1] = 1'b0;
        check("ws0_b2b_ready", vec, 32'h0000_0055);
        check("ws0_b2b_sb_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        txn(1, 1'b1, 32'h0000_0008, 32'hCAFE_0008, 32'h1234_5678, 1'b0, 1'b0, "ws0_wr8");
        txn(1, 1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_0008, 1'b0, 1'b0, "ws0_rd8");
`ifdef MEM_RESP_ALIGN_CHECK_EN
        txn(1, 1'b0, 32'h0000_0006, 32'h0,         32'hCAFE_0008, 1'b1, 1'b0, "ws0_rd6");
`else
        txn(1, 1'b0, 32'h0000_0006, 32'h0,         32'h1234_5678, 1'b0, 1'b0, "ws0_rd6");
`endif

        // WAIT_STATES = 3: a Req (write to 0x24) during WAIT must be ignored.
        txn(2, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0, "ws3_wr20");
        txn(2, 1'b1, 32'h0000_0024, 32'h2424_2424, 32'h0000_0000, 1'b0, 1'b0, "ws3_wr24");
        txn(2, 1'b0, 32'h0000_0020, 32'h0,         32'hA5A5_A5A5, 1'b0, 1'b1, "ws3_rd20_glitch");
        txn(2, 1'b0, 32'h0000_0024, 32'h0,         32'h2424_2424, 1'b0, 1'b0, "ws3_rd24");

        // Reset mid-WAIT aborts a write before its access edge.
        @(negedge clk);
        req[2]  = 1'b1;
        wr[2]   = 1'b1;
        addr[2] = 32'h0000_0020;
        din[2]  = 32'h5A5A_5A5A;
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        check("ws3_pre_rst_busy", {31'd0, busy[2]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("ws3_rst_ready", {31'd0, rdy[2]}, 32'd0);
        check("ws3_rst_busy", {31'd0, busy[2]}, 32'd0);
        check("ws3_rst_dataout", dout[2], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[2]) rcnt++;
        end
        check("ws3_rst_no_ready", 32'(rcnt), 32'd0);
        txn(2, 1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0, "ws3_rd20_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Word-addressed memory responder that sits on the far side of the CPU's memory port. It serves the CPU's read/write requests (Address, Wr, Datain) with a configurable number of wait states and a Ready/Err completion handshake, so the multicycle control FSM can stall on slow memory. It holds its own word storage and replaces the fixed-latency memory model on the CPU datapath.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, at least 4.
- WAIT_STATES, 1, extra cycles between request acceptance and completion; valid range 0..15.
- ABITS, $clog2(DEPTH_WORDS), word-index width; derived, do not override.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  request strobe; sampled only in IDLE.
- Wr  in  1  1 = write, 0 = read; sampled with Req.
- Address  in  32  byte address; word index = Address[ABITS+1:2].
- Datain  in  32  write data; sampled with Req.
- Dataout  out  32  read data; valid while Ready=1, held afterwards.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  error flag; meaningful only while Ready=1.
- Busy  out  1  high in WAIT and RESP.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; Dataout=0, Ready=0, Err=0, Busy=0; wait counter=0; latched request registers=0.
  - Storage array is not reset.
- States: IDLE, WAIT, RESP; encoding defined in the package.
- IDLE:
  - If Req=1 at a rising edge, latch Wr, Address and Datain.
  - If WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
  - If WAIT_STATES=0: perform the access on this same edge and go to RESP.
- WAIT:
  - Counter>0: decrement it and stay in WAIT.
  - Counter=0: perform the access on this edge and go to RESP.
- Performing the access, all on one edge:
  - Write: array[idx] <= latched Datain.
  - Read: Dataout <= array[idx].
  - Err <= error condition.
- RESP:
  - Ready=1 and Busy=1 for exactly one cycle, then unconditionally to IDLE.
- Latency: the Req sample edge to the first cycle with Ready=1 is WAIT_STATES+1 cycles. Maximum throughput is one transaction per WAIT_STATES+2 cycles.
- Req is ignored outside IDLE; in-flight latched values are not disturbed by input changes.
- Out of range (Address[31:ABITS+2] != 0):
  - Err=1 with Ready.
  - Write suppressed.
  - Read leaves Dataout unchanged.
- A write does not change Dataout. Dataout holds the last successful read data until the next successful read.
- Read after write to the same word in back-to-back transactions returns the new data.
- Reset asserted mid-transaction: the transaction is aborted and no Ready is issued. A write is lost unless its access edge has already occurred.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MEM_RESP_ALIGN_CHECK_EN.
- Defined: Address[1:0] != 0 is an error with the same handling as out of range (Err=1, write suppressed, Dataout unchanged). Latency is unchanged.
- Undefined: Address[1:0] is ignored, and Err reflects out-of-range only.

Decomposition:
- Package mem_resp_pkg:
  - state enum typedef (IDLE/WAIT/RESP).
  - WORD_W=32.
  - MAX_WAIT=15.
  - Counter width constant.
- Sub-module mem_word_array: synchronous-write, registered-read word RAM.
  - Ports: Clk, we, re, idx, wdata, rdata.
  - No reset.
  - The FSM, counter and error logic stay in mem_responder.

Test Plan:
- Reset: drive Reset=0 mid-WAIT -> Ready=0, Busy=0, Dataout=0 immediately; after release, no Ready appears.
- Write then read, WAIT_STATES=1: write Address=0x0000_0010, Datain=0xDEAD_BEEF; then read 0x10.
  - Each Ready arrives exactly 2 cycles after Req.
  - Read returns Dataout=0xDEAD_BEEF, Err=0.
  - Dataout is unchanged after the write.
- WAIT_STATES=0: read of a previously written 0x1234_5678 at 0x4 -> Ready 1 cycle after Req. Back-to-back Req held high yields Ready every 2 cycles.
- Out of range, DEPTH_WORDS=256: write to 0x0000_0400 -> Err=1 with Ready, array unchanged. Subsequent read of 0x0 returns the old value, and the read of 0x400 leaves Dataout unchanged with Err=1.
- Req ignored while busy: WAIT_STATES=3, pulse a second Req with a different Address during WAIT -> exactly one Ready at cycle 4, for the first address only.
- Alignment, macro defined: read 0x0000_0006 -> Err=1, Dataout held. Without the macro -> Err=0 and the word at 0x4 is returned.
